// File: rtl/nec_ir_receiver.sv
// NEC infrared frame decoder: times marks and spaces with a 10 us tick and
// presents each complete 32-bit frame on dataOUT with a one-cycle strobe.
module nec_ir_receiver #(
  parameter int CLOCK_SPEED = 50_000_000
) (
  input  logic        clkIN,
  input  logic        nResetIN,
  input  logic        rxIN,
  output logic        dataReceivedOUT,
  output logic [31:0] dataOUT
);

  localparam int TICK_DIV = CLOCK_SPEED / 100_000;
  localparam int TICK_W   = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [10:0] DUR_MAX = 11'd2047;
  localparam logic [10:0] TIMEOUT = 11'd1100;

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK
  } state_t;

  state_t            state, stateNext;
  logic              rxMeta_p0, rxSync_p1, rxPrev_p2;
  logic              rise, fall, anyEdge, tick, timeout;
  logic [TICK_W-1:0] tickCnt;
  logic [10:0]       durCnt;
  logic [4:0]        bitCnt;
  logic [31:0]       frameReg;
  logic              bitClr, bitStore, bitVal, loadOut;

  function automatic logic inRange(input logic [10:0] d, input logic [10:0] lo,
                                   input logic [10:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  // Stage p0/p1: synchronizer; p2: previous sample for edge detection
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      rxMeta_p0 <= 1'b0;
      rxSync_p1 <= 1'b0;
      rxPrev_p2 <= 1'b0;
    end else begin
      rxMeta_p0 <= rxIN;
      rxSync_p1 <= rxMeta_p0;
      rxPrev_p2 <= rxSync_p1;
    end
  end

  assign rise    = rxSync_p1 & ~rxPrev_p2;
  assign fall    = ~rxSync_p1 & rxPrev_p2;
  assign anyEdge = rise | fall;
  assign tick    = (tickCnt == TICK_LAST);
  assign timeout = (state != IDLE) && (durCnt >= TIMEOUT);

  // Both timers restart on every line edge so durCnt reads the phase length
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      tickCnt <= '0;
      durCnt  <= '0;
    end else if (anyEdge) begin
      tickCnt <= '0;
      durCnt  <= '0;
    end else begin
      tickCnt <= tick ? '0 : tickCnt + TICK_W'(1);
      if (tick && durCnt != DUR_MAX) durCnt <= durCnt + 11'd1;
    end
  end

  always_comb begin
    stateNext = state;
    bitClr    = 1'b0;
    bitStore  = 1'b0;
    bitVal    = 1'b0;
    loadOut   = 1'b0;
    if (timeout) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:       if (rise) stateNext = LEAD_MARK;
        LEAD_MARK:  if (fall) stateNext = inRange(durCnt, 11'd800, 11'd1000) ? LEAD_SPACE : IDLE;
        LEAD_SPACE: if (rise) begin
          if (inRange(durCnt, 11'd400, 11'd500)) begin
            bitClr    = 1'b1;
            stateNext = BIT_MARK;
          end else begin
            stateNext = IDLE;
          end
        end
        BIT_MARK:   if (fall) stateNext = inRange(durCnt, 11'd40, 11'd75) ? BIT_SPACE : IDLE;
        BIT_SPACE:  if (rise) begin
          if (inRange(durCnt, 11'd40, 11'd75) || inRange(durCnt, 11'd140, 11'd190)) begin
            bitStore  = 1'b1;
            bitVal    = inRange(durCnt, 11'd140, 11'd190);
            stateNext = (bitCnt == 5'd31) ? STOP_MARK : BIT_MARK;
          end else begin
            stateNext = IDLE;
          end
        end
        STOP_MARK:  if (fall) begin
          loadOut   = inRange(durCnt, 11'd40, 11'd75);
          stateNext = IDLE;
        end
        default:    stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state           <= IDLE;
      bitCnt          <= '0;
      dataReceivedOUT <= 1'b0;
      dataOUT         <= '0;
    end else begin
      state           <= stateNext;
      dataReceivedOUT <= loadOut;
      if (bitClr)        bitCnt <= '0;
      else if (bitStore) bitCnt <= bitCnt + 5'd1;
      if (loadOut)       dataOUT <= frameReg;
    end
  end

  // Bytes arrive LSB first; byte n lands in dataOUT[31-8n -: 8]
  always_ff @(posedge clkIN) begin
    if (bitStore) frameReg[{~bitCnt[4:3], bitCnt[2:0]}] <= bitVal;
  end

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Bench for nec_ir_receiver: table-driven frames plus timeout and reset
// sequences, with randomized frames checked against a timing-rule model.
module tb_nec_ir_receiver;

  localparam int CS  = 200_000;
  localparam int DIV = CS / 100_000;

  logic        clk;
  logic        nReset;
  logic        rx;
  logic        dataReceived;
  logic [31:0] dataOut;

  nec_ir_receiver #(.CLOCK_SPEED(CS)) dut (
    .clkIN          (clk),
    .nResetIN       (nReset),
    .rxIN           (rx),
    .dataReceivedOUT(dataReceived),
    .dataOUT        (dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          cyc = 0;
  int          pulses = 0;
  int          pulseCyc = 0;
  int          badChanges = 0;
  logic [31:0] prevOut = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (nReset) begin
      if (dataReceived) begin
        pulses   <= pulses + 1;
        pulseCyc <= cyc;
      end else if (dataOut !== prevOut) begin
        badChanges <= badChanges + 1;
      end
    end
    prevOut <= dataOut;
  end

  initial begin
    #1_600_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int asserts = 0;
  int fails   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Current frame timing, in 10 us ticks
  int leadM, leadS, stopT, stopCyc;
  int markT[32];
  int spaceT[32];

  function automatic int jv(input bit jit);
    return jit ? int'($urandom_range(4)) - 2 : 0;
  endfunction

  task automatic build(input logic [31:0] word, input int pct, input bit jit);
    logic [7:0] b;
    leadM = 900 * pct / 100 + jv(jit);
    leadS = 450 * pct / 100 + jv(jit);
    for (int k = 0; k < 32; k++) begin
      b = word[31 - 8 * (k / 8) -: 8];
      markT[k]  = 5625 * pct / 10000 + jv(jit);
      spaceT[k] = (b[k % 8] ? 16875 * pct / 10000 : 5625 * pct / 10000) + jv(jit);
    end
    stopT = 5625 * pct / 10000 + jv(jit);
  endtask

  function automatic bit inR(input int d, input int lo, input int hi);
    return (d >= lo) && (d <= hi);
  endfunction

  // Reference: a frame decodes only if every phase meets its window
  task automatic model(input int nbits, output bit valid, output logic [31:0] w);
    valid = inR(leadM, 800, 1000) && inR(leadS, 400, 500) && (nbits == 32) && inR(stopT, 40, 75);
    w = '0;
    for (int k = 0; k < nbits; k++) begin
      if (!inR(markT[k], 40, 75)) valid = 1'b0;
      if (inR(spaceT[k], 140, 190)) w[(31 - 8 * (k / 8)) - 7 + (k % 8)] = 1'b1;
      else if (!inR(spaceT[k], 40, 75)) valid = 1'b0;
    end
  endtask

  task automatic level(input logic v, input int ticks);
    rx = v;
    repeat (ticks * DIV) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input int k);
    level(1'b1, markT[k]);
    level(1'b0, spaceT[k]);
  endtask

  task automatic sendFrame(input int nbits, input int tailLow);
    level(1'b1, leadM);
    level(1'b0, leadS);
    for (int k = 0; k < nbits; k++) sendBit(k);
    level(1'b1, stopT);
    stopCyc = cyc;
    level(1'b0, tailLow);
  endtask

  task automatic checkFrame(input string name, input int pBefore, input bit expPulse,
                            input logic [31:0] expWord);
    chk({name, "_pulses"}, pulses - pBefore, {31'b0, expPulse});
    chk({name, "_data"}, dataOut, expWord);
    if (expPulse) chk({name, "_latency"}, pulseCyc - stopCyc, 3);
  endtask

  typedef struct {
    logic [31:0] word;
    int          pct;
    int          leadMOvr;
    int          leadSOvr;
    int          nbits;
    bit          expPulse;
    logic [31:0] expWord;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] lastWord;
  logic [31:0] w;
  bit          v;
  int          pb;

  initial begin
    vecs[0] = '{32'h00FF02FD, 100,   0,   0, 32, 1'b1, 32'h00FF02FD};
    vecs[1] = '{32'h00FF22DD, 110,   0,   0, 32, 1'b1, 32'h00FF22DD};
    vecs[2] = '{32'h00FF02FD, 100, 900, 225,  0, 1'b0, 32'h00FF22DD};
    vecs[3] = '{32'h00FF02FD, 100, 500, 450,  8, 1'b0, 32'h00FF22DD};

    rx     = 1'b0;
    nReset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_strobe", {31'b0, dataReceived}, 32'd0);
    chk("reset_data", dataOut, 32'd0);
    nReset = 1'b1;

    level(1'b0, 2000);
    chk("idle_pulses", pulses, 0);
    chk("idle_data", dataOut, 32'd0);

    for (int i = 0; i < 4; i++) begin
      build(vecs[i].word, vecs[i].pct, 1'b0);
      if (vecs[i].leadMOvr != 0) leadM = vecs[i].leadMOvr;
      if (vecs[i].leadSOvr != 0) leadS = vecs[i].leadSOvr;
      pb = pulses;
      sendFrame(vecs[i].nbits, 50 + int'($urandom_range(50)));
      checkFrame($sformatf("vec%0d", i), pb, vecs[i].expPulse, vecs[i].expWord);
    end
    lastWord = vecs[3].expWord;

    // Line held low 15 ms after bit 10's mark, then a full -10% frame
    build($urandom, 90, 1'b1);
    stopT = markT[10];
    pb = pulses;
    sendFrame(10, 1500);
    model(10, v, w);
    if (v) lastWord = w;
    checkFrame("timeout", pb, v, lastWord);

    build($urandom, 90, 1'b1);
    pb = pulses;
    sendFrame(32, 50 + int'($urandom_range(50)));
    model(32, v, w);
    if (v) lastWord = w;
    checkFrame("after_timeout", pb, v, lastWord);

    // Reset pulse in the middle of bit 20's mark
    build($urandom, 90, 1'b1);
    pb = pulses;
    level(1'b1, leadM);
    level(1'b0, leadS);
    for (int k = 0; k < 20; k++) sendBit(k);
    level(1'b1, 20);
    nReset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_strobe", {31'b0, dataReceived}, 32'd0);
    chk("midreset_data", dataOut, 32'd0);
    nReset = 1'b1;
    level(1'b1, markT[20] - 20);
    level(1'b0, spaceT[20]);
    for (int k = 21; k < 32; k++) sendBit(k);
    level(1'b1, stopT);
    level(1'b0, 60);
    chk("remainder_pulses", pulses - pb, 0);
    chk("remainder_data", dataOut, 32'd0);
    lastWord = '0;

    build($urandom, 90, 1'b1);
    pb = pulses;
    sendFrame(32, 50 + int'($urandom_range(50)));
    model(32, v, w);
    if (v) lastWord = w;
    checkFrame("after_reset", pb, v, lastWord);

    chk("unstrobed_changes", badChanges, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
